jts16_busarb: RTL
=================

# jts16_busarb

Bus-arbitration controller that lets a secondary master (i8751 MCU bridge or sprite/palette DMA) borrow the System 16 68000 bus. It runs the 68000 BRn/BGn/BGACKn handshake against `jtframe_m68k`, then drives one or more word accesses onto the shared main-board bus (RAM, VRAM, char, palette, object RAM decode). It returns the bus after an idle hold window or a fixed access budget, so the CPU is never starved.

## Interface
Parameters:
- HOLDW, 4: width of the idle-hold counter. The bus is held for `2^HOLDW-1` clk after the last access while waiting for a follow-up request.
- MAXACC, 16: maximum accesses per grant before a forced release.
- ACCTO, 255: clk cycles to wait for `bus_ok` before aborting an access.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low. The single clock is `clk`.
- `cpu_cen` in 1: CPU clock enable. `BRn` and `BGACKn` change only when this is high.
- `BRn` out 1: bus request to the CPU.
- `BGn` in 1: bus grant from the CPU.
- `BGACKn` out 1: bus grant acknowledge to the CPU.
- `cpu_ASn` in 1: CPU address strobe.
- `cpu_DTACKn` in 1: DTACK currently presented to the CPU.
- `req` in 1: access request from the master. Level signal, held until `ack`.
- `req_we` in 1: write when high.
- `req_addr` in 23: word address A[23:1].
- `req_dsn` in 2: {UDSn, LDSn} for the access.
- `req_din` in 16: write data.
- `ack` out 1: one-cycle pulse when the access completes.
- `err` out 1: valid together with `ack`; high means the access timed out.
- `rd_data` out 16: read data, valid from `ack` until the next `ack`.
- `bus_sel` out 1: high while the arbiter owns the bus. The top level uses it to mux the address, data and strobes.
- `arb_addr` out 23: address driven onto the bus.
- `arb_dout` out 16: write data driven onto the bus.
- `arb_ASn` out 1: address strobe driven onto the bus.
- `arb_UDSn` out 1: upper data strobe driven onto the bus.
- `arb_LDSn` out 1: lower data strobe driven onto the bus.
- `arb_RnW` out 1: read/write driven onto the bus.
- `bus_din` in 16: read data returned from the bus.
- `bus_ok` in 1: memory ready. Same meaning as the internal DTACK condition on the bus.

## Operation
States: IDLE, REQ, WAITREL, OWN, ACC, DONE, REL.

- **IDLE:** on `req`, go to REQ.
- **REQ:** assert `BRn` low on the next `cpu_cen`. Wait for `BGn` low.
- **WAITREL:** wait until `BGn` is low, `cpu_ASn` is high and `cpu_DTACKn` is high, all sampled on the same `cpu_cen`. Then, on that `cpu_cen`:
  - drive `BGACKn` low and `BRn` high;
  - set `bus_sel`;
  - clear the access counter;
  - go to OWN.
- **OWN:**
  - If `req` is high and the access counter is below MAXACC: latch addr/we/dsn/din, drive `arb_ASn` low with the strobes from `req_dsn`, set `arb_RnW = !req_we`, clear the timeout counter, go to ACC.
  - Otherwise increment the hold counter. On hold-counter overflow, or when the access counter equals MAXACC, go to REL.
  - The hold counter clears on every access.
- **ACC:**
  - When `bus_ok` is high: latch `bus_din` into `rd_data` (reads only; writes leave `rd_data` unchanged), pulse `ack`, raise all strobes, increment the access counter, go to DONE.
  - When the timeout counter reaches ACCTO: pulse `ack` and `err`, set `rd_data = 16'hFFFF`, raise strobes, go to DONE.
- **DONE:** one cycle with strobes high, so downstream RAM request logic sees the chip select toggle. Then go to OWN.
- **REL:** on the next `cpu_cen`, raise `BGACKn`, clear `bus_sel`, go to IDLE. A pending `req` is re-requested from IDLE one cycle later. This guarantees the CPU at least one bus cycle between grants.

Reset (`rstn` low at a `clk` edge) outputs:
- `BRn`, `BGACKn`, `arb_ASn`, `arb_UDSn`, `arb_LDSn`, `arb_RnW`: 1.
- `bus_sel`, `ack`, `err`: 0.
- `rd_data`, `arb_addr`, `arb_dout`: 0.
- State: IDLE.

Reset in the middle of an access drops ownership immediately, with no handshake. The CPU is reset by the same `rstn`.

Counters saturate; they never wrap. `req_dsn = 2'b11` is still performed as a full access: strobes stay high and the access ends on `bus_ok` or the timeout.

## Timing
- `BRn` falls on the first `cpu_cen` after `req` is seen in IDLE. Minimum latency from `req` to `BRn` low is 2 clk.
- `arb_ASn` falls 1 clk after OWN samples `req`.
- `ack` is asserted 1 clk after `bus_ok` is sampled high in ACC.
- Back-to-back accesses within one grant are 3 clk apart at minimum (OWN→ACC→DONE) when `bus_ok` is immediate.
- `BGn` going high while in OWN or ACC is ignored: the 68000 keeps the bus released while BGACKn is low.
- If `req` drops before the grant arrives: the handshake still completes, then the block goes through the hold window and REL.

## Structure
- A shared `jts16_busarb_pkg` holds the state enum encoding (3 bits) and the default HOLDW/MAXACC/ACCTO constants.
- One sub-module is natural: `jts16_busarb_cnt`, a saturating counter with clear, enable and a terminal flag. It is instantiated three times: hold, access budget, timeout.
- All outputs are registered.

## Test plan
- **Single read:** `req` with addr `23'h200000`, `bus_ok` 2 clk after `arb_ASn` low, `bus_din = 16'h1234`. Expect BRn→BGn→BGACKn sequence, `ack` with `rd_data = 16'h1234`, then REL after 15 idle clk.
- **Grant deferral:** grant during an active CPU cycle (`cpu_ASn` low for 6 `cpu_cen`). Expect `BGACKn` low only on the first `cpu_cen` after `cpu_ASn` and `cpu_DTACKn` are both high.
- **Burst limit:** 20 back-to-back write requests. Expect 16 acks, REL, `BGACKn` high for at least one `cpu_cen`, then re-request; the remaining 4 complete in a second grant.
- **Timeout:** `bus_ok` held low. Expect `ack`+`err` 255 clk after `arb_ASn` falls, with `rd_data = 16'hFFFF`.
- **Reset mid-ACC:** `rstn` low during ACC. Expect `bus_sel = 0`, `BGACKn = 1` and all strobes high on the next clk edge.
- **Write strobes:** `req_dsn = 2'b01`, `req_we = 1`. Expect `arb_UDSn = 0`, `arb_LDSn = 1`, `arb_RnW = 0`, and `rd_data` unchanged.

Source files
------------

// File: rtl/jts16_busarb_pkg.sv
// Shared definitions for the System 16 bus arbiter.
// Holds the FSM state encoding, the default sizing constants and a helper
// that sizes a saturating counter for a given terminal value.

package jts16_busarb_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StReq     = 3'd1,
      StWaitRel = 3'd2,
      StOwn     = 3'd3,
      StAcc     = 3'd4,
      StDone    = 3'd5,
      StRel     = 3'd6
   } state_e;

   localparam int unsigned HoldWDef  = 4;
   localparam int unsigned MaxAccDef = 16;
   localparam int unsigned AccToDef  = 255;

   // Bits needed to hold the values 0..max_val inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/jts16_busarb_cnt.sv
// Saturating up-counter with synchronous clear, enable and a terminal flag.
// Ports:
//   clk  - clock
//   rstn - synchronous active-low reset
//   clr  - clear to zero (wins over en)
//   en   - count up by one; holds at MaxVal instead of wrapping
//   hit  - terminal flag: count == MaxVal, or count == MaxVal-1 when Early
//          is set (lets the caller act on the same edge the terminal count
//          would be reached)

module jts16_busarb_cnt #(
   parameter int unsigned Width  = 4,
   parameter int unsigned MaxVal = 15,
   parameter bit          Early  = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [Width-1:0] MaxV = Width'(MaxVal);
   localparam logic [Width-1:0] HitV = Early ? Width'(MaxVal - 1) : Width'(MaxVal);

   logic [Width-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != MaxV)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit = (cnt_q == HitV);

endmodule

// File: rtl/jts16_busarb.sv
// Bus arbiter letting a secondary master (MCU bridge or DMA) borrow the
// 68000 bus. Runs the BRn/BGn/BGACKn handshake, then performs word accesses
// on the shared bus until the master goes idle for the hold window or the
// per-grant access budget is spent.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   cpu_cen              - CPU clock enable; BRn/BGACKn only move on it
//   BRn, BGn, BGACKn     - 68000 arbitration handshake
//   cpu_ASn, cpu_DTACKn  - CPU bus cycle status, used to defer takeover
//   req, req_we, req_addr, req_dsn, req_din - master request (level, held
//                          until ack)
//   ack, err, rd_data    - completion pulse, timeout flag, read data
//   bus_sel              - high while the arbiter owns the bus
//   arb_*                - address/data/strobes driven onto the bus
//   bus_din, bus_ok      - read data and ready from the bus
// All outputs are registered.

module jts16_busarb
   import jts16_busarb_pkg::*;
#(
   parameter int unsigned HOLDW  = HoldWDef,
   parameter int unsigned MAXACC = MaxAccDef,
   parameter int unsigned ACCTO  = AccToDef
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cpu_cen,
   output logic        BRn,
   input  logic        BGn,
   output logic        BGACKn,
   input  logic        cpu_ASn,
   input  logic        cpu_DTACKn,
   input  logic        req,
   input  logic        req_we,
   input  logic [22:0] req_addr,
   input  logic [1:0]  req_dsn,
   input  logic [15:0] req_din,
   output logic        ack,
   output logic        err,
   output logic [15:0] rd_data,
   output logic        bus_sel,
   output logic [22:0] arb_addr,
   output logic [15:0] arb_dout,
   output logic        arb_ASn,
   output logic        arb_UDSn,
   output logic        arb_LDSn,
   output logic        arb_RnW,
   input  logic [15:0] bus_din,
   input  logic        bus_ok
);

   localparam int unsigned HoldMax = (32'd1 << HOLDW) - 32'd1;
   localparam int unsigned AccW    = cnt_width(MAXACC);
   localparam int unsigned ToW     = cnt_width(ACCTO);

   state_e      state_d, state_q;
   logic        brn_d, brn_q;
   logic        bgackn_d, bgackn_q;
   logic        bus_sel_d, bus_sel_q;
   logic        ack_d, ack_q;
   logic        err_d, err_q;
   logic [15:0] rd_data_d, rd_data_q;
   logic [22:0] addr_d, addr_q;
   logic [15:0] dout_d, dout_q;
   logic        asn_d, asn_q;
   logic        udsn_d, udsn_q;
   logic        ldsn_d, ldsn_q;
   logic        rnw_d, rnw_q;

   logic hold_full, acc_full, to_hit;
   logic grant, start_acc;

   // Take the bus only once the CPU has granted it and its own cycle is over.
   assign grant = (state_q == StWaitRel) && cpu_cen && !BGn && cpu_ASn && cpu_DTACKn;
   assign start_acc = (state_q == StOwn) && req && !acc_full;

   // Idle-hold window: runs only while owning the bus with nothing to do.
   jts16_busarb_cnt #(
      .Width  (HOLDW),
      .MaxVal (HoldMax),
      .Early  (1'b0)
   ) u_hold_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  ((state_q != StOwn) || start_acc),
      .en   ((state_q == StOwn) && !start_acc),
      .hit  (hold_full)
   );

   // Access budget per grant; only successful accesses consume it.
   jts16_busarb_cnt #(
      .Width  (AccW),
      .MaxVal (MAXACC),
      .Early  (1'b0)
   ) u_acc_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (grant),
      .en   ((state_q == StAcc) && bus_ok),
      .hit  (acc_full)
   );

   // Early flag so ack/err land exactly ACCTO clk after the strobe falls.
   jts16_busarb_cnt #(
      .Width  (ToW),
      .MaxVal (ACCTO),
      .Early  (1'b1)
   ) u_to_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (start_acc),
      .en   (state_q == StAcc),
      .hit  (to_hit)
   );

   always_comb begin
      state_d   = state_q;
      brn_d     = brn_q;
      bgackn_d  = bgackn_q;
      bus_sel_d = bus_sel_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rd_data_d = rd_data_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      asn_d     = asn_q;
      udsn_d    = udsn_q;
      ldsn_d    = ldsn_q;
      rnw_d     = rnw_q;

      case (state_q)
         StIdle: begin
            if (req) state_d = StReq;
         end
         StReq: begin
            if (cpu_cen) begin
               brn_d   = 1'b0;
               state_d = StWaitRel;
            end
         end
         StWaitRel: begin
            if (grant) begin
               bgackn_d  = 1'b0;
               brn_d     = 1'b1;
               bus_sel_d = 1'b1;
               state_d   = StOwn;
            end
         end
         StOwn: begin
            if (start_acc) begin
               addr_d  = req_addr;
               dout_d  = req_din;
               asn_d   = 1'b0;
               udsn_d  = req_dsn[1];
               ldsn_d  = req_dsn[0];
               rnw_d   = !req_we;
               state_d = StAcc;
            end else if (hold_full || acc_full) begin
               state_d = StRel;
            end
         end
         StAcc: begin
            if (bus_ok) begin
               if (rnw_q) rd_data_d = bus_din;
               ack_d   = 1'b1;
               asn_d   = 1'b1;
               udsn_d  = 1'b1;
               ldsn_d  = 1'b1;
               state_d = StDone;
            end else if (to_hit) begin
               rd_data_d = 16'hFFFF;
               ack_d     = 1'b1;
               err_d     = 1'b1;
               asn_d     = 1'b1;
               udsn_d    = 1'b1;
               ldsn_d    = 1'b1;
               state_d   = StDone;
            end
         end
         // One cycle with strobes high so downstream chip selects toggle.
         StDone: begin
            state_d = StOwn;
         end
         StRel: begin
            if (cpu_cen) begin
               bgackn_d  = 1'b1;
               bus_sel_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Reset drops ownership at once; the CPU shares this reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= StIdle;
         brn_q     <= 1'b1;
         bgackn_q  <= 1'b1;
         bus_sel_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
         addr_q    <= '0;
         dout_q    <= '0;
         asn_q     <= 1'b1;
         udsn_q    <= 1'b1;
         ldsn_q    <= 1'b1;
         rnw_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         brn_q     <= brn_d;
         bgackn_q  <= bgackn_d;
         bus_sel_q <= bus_sel_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_data_q <= rd_data_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         asn_q     <= asn_d;
         udsn_q    <= udsn_d;
         ldsn_q    <= ldsn_d;
         rnw_q     <= rnw_d;
      end
   end

   assign BRn      = brn_q;
   assign BGACKn   = bgackn_q;
   assign bus_sel  = bus_sel_q;
   assign ack      = ack_q;
   assign err      = err_q;
   assign rd_data  = rd_data_q;
   assign arb_addr = addr_q;
   assign arb_dout = dout_q;
   assign arb_ASn  = asn_q;
   assign arb_UDSn = udsn_q;
   assign arb_LDSn = ldsn_q;
   assign arb_RnW  = rnw_q;

endmodule
